// File: rtl/rle_param.sv
// Run-length compressor: reads plaintext words from a single-port SRAM and
// writes (symbol, count) byte pairs back to it, packed four bytes per word.
//
// state   | meaning
// IDLE    | waiting for start
// RD_REQ  | read address presented on port A
// RD_WAIT | SRAM read latency
// SCAN    | one input byte per cycle
// WRITE   | one output word, port_A_we high
// FLUSH   | close the open pair, emit the final word
// DONE    | result valid, held until next start

module rle_param #(
  parameter int ADDR_W    = 16,
  parameter int MAX_RUN   = 255,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  input  logic [31:0]       rle_addr,
  output logic [31:0]       rle_size,
  output logic              done,
  output logic              busy,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  output logic              port_A_we
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_SCAN, S_WRITE, S_FLUSH, S_DONE
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_RUN);

  state_t            state_q, state_d;
  logic [31:0]       rd_ptr_q, rd_ptr_d;
  logic [31:0]       wr_ptr_q, wr_ptr_d;
  logic [31:0]       remain_q, remain_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        sym_q, sym_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       obuf_q, obuf_d;
  logic              half_q, half_d;
  logic              last_q, last_d;
  logic [31:0]       size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept;
  logic              run_ext;
  logic              close_scan;
  logic [7:0]        cur_byte;
  logic [31:0]       pair_word;

  // Pairs are two bytes and words four, so the output buffer is always empty
  // or exactly half full; half_q selects which half the next pair lands in.
  function automatic logic [31:0] place_pair(input logic [7:0] s,
                                             input logic [7:0] c,
                                             input logic       h);
    if (MSB_FIRST) return h ? {16'h0000, s, c} : {s, c, 16'h0000};
    else           return h ? {c, s, 16'h0000} : {16'h0000, c, s};
  endfunction

  always_comb begin
    cur_byte = 8'h00;
    if (MSB_FIRST) begin
      case (idx_q)
        2'd0:    cur_byte = word_q[31:24];
        2'd1:    cur_byte = word_q[23:16];
        2'd2:    cur_byte = word_q[15:8];
        default: cur_byte = word_q[7:0];
      endcase
    end else begin
      case (idx_q)
        2'd0:    cur_byte = word_q[7:0];
        2'd1:    cur_byte = word_q[15:8];
        2'd2:    cur_byte = word_q[23:16];
        default: cur_byte = word_q[31:24];
      endcase
    end
  end

  assign accept     = start && (state_q == S_IDLE || state_q == S_DONE);
  assign run_ext    = (cur_byte == sym_q) && (cnt_q < MAX_CNT);
  assign close_scan = (state_q == S_SCAN) && (cnt_q != 8'd0) && !run_ext;
  assign pair_word  = obuf_q | place_pair(sym_q, cnt_q, half_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = (message_size == 32'd0) ? S_DONE : S_RD_REQ;
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_SCAN;
      S_SCAN: begin
        if (close_scan && half_q)     state_d = S_WRITE;
        else if (remain_q == 32'd1)   state_d = S_FLUSH;
        else if (idx_q == 2'd3)       state_d = S_RD_REQ;
        else                          state_d = S_SCAN;
      end
      S_WRITE: begin
        if (last_q)                   state_d = S_DONE;
        else if (remain_q == 32'd0)   state_d = S_FLUSH;
        else if (idx_q == 2'd0)       state_d = S_RD_REQ;
        else                          state_d = S_SCAN;
      end
      S_FLUSH: state_d = (cnt_q != 8'd0 || half_q) ? S_WRITE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    port_A_we = (state_q == S_WRITE);
    busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    done      = (state_q == S_DONE);
  end

  assign port_A_clk     = clk;
  assign port_A_addr    = addr_q;
  assign port_A_data_in = wdata_q;
  assign rle_size       = size_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    remain_d = remain_q;
    word_d   = word_q;
    idx_d    = idx_q;
    sym_d    = sym_q;
    cnt_d    = cnt_q;
    obuf_d   = obuf_q;
    half_d   = half_q;
    last_d   = last_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          rd_ptr_d = message_addr;
          wr_ptr_d = rle_addr;
          remain_d = message_size;
          idx_d    = 2'd0;
          sym_d    = 8'h00;
          cnt_d    = 8'd0;
          obuf_d   = 32'h0;
          half_d   = 1'b0;
          last_d   = 1'b0;
          size_d   = 32'd0;
          addr_d   = message_addr[ADDR_W-1:0];
        end
      end
      S_RD_REQ:  rd_ptr_d = rd_ptr_q + 32'd4;
      S_RD_WAIT: word_d   = port_A_data_out;
      S_SCAN: begin
        remain_d = remain_q - 32'd1;
        idx_d    = idx_q + 2'd1;
        if (cnt_q == 8'd0 || close_scan) begin
          sym_d = cur_byte;
          cnt_d = 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (close_scan) begin
          size_d = size_q + 32'd2;
          if (half_q) begin
            addr_d   = wr_ptr_q[ADDR_W-1:0];
            wdata_d  = pair_word;
            wr_ptr_d = wr_ptr_q + 32'd4;
            obuf_d   = 32'h0;
            half_d   = 1'b0;
          end else begin
            obuf_d = pair_word;
            half_d = 1'b1;
          end
        end
        if (state_d == S_RD_REQ) addr_d = rd_ptr_q[ADDR_W-1:0];
      end
      S_WRITE: begin
        if (state_d == S_RD_REQ) addr_d = rd_ptr_q[ADDR_W-1:0];
      end
      S_FLUSH: begin
        if (cnt_q != 8'd0) begin
          size_d  = size_q + 32'd2;
          cnt_d   = 8'd0;
          wdata_d = pair_word;
        end else begin
          wdata_d = obuf_q;
        end
        if (cnt_q != 8'd0 || half_q) begin
          addr_d   = wr_ptr_q[ADDR_W-1:0];
          wr_ptr_d = wr_ptr_q + 32'd4;
          obuf_d   = 32'h0;
          half_d   = 1'b0;
          last_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 32'h0;
      wr_ptr_q <= 32'h0;
      remain_q <= 32'h0;
      word_q   <= 32'h0;
      idx_q    <= 2'd0;
      sym_q    <= 8'h00;
      cnt_q    <= 8'd0;
      obuf_q   <= 32'h0;
      half_q   <= 1'b0;
      last_q   <= 1'b0;
      size_q   <= 32'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      remain_q <= remain_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      sym_q    <= sym_d;
      cnt_q    <= cnt_d;
      obuf_q   <= obuf_d;
      half_q   <= half_d;
      last_q   <= last_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule
